score_panel_ctrl: RTL and testbench
===================================

// Module: score_panel_ctrl
// PURPOSE
//  Sequencer for the side-panel score glyph renderer (draw_score).
//  - Tracks the four tank scores and finds which glyphs are stale.
//  - For each stale glyph it wins the shared VGA write port, runs one erase pass, then one draw pass.
//  - Feeds the renderer latched score copies, so a glyph never changes in the middle of a pass.
// PARAMETERS
//  BG_COLOUR  3'b000  colour written during the erase pass
//  T1_COLOUR  3'b100  glyph colour for tank 0; T2_COLOUR 3'b010, T3_COLOUR 3'b001, T4_COLOUR 3'b110 likewise
// PORTS
//  clk          in   1  system clock
//  resetn       in   1  reset, synchronous, active-low
//  t1,t2,t3,t4  in   3  live tank scores from game logic
//  refresh      in   1  one-cycle pulse; marks all four glyphs stale
//  bus_grant    in   1  VGA write-port grant from the frame arbiter
//  draw_finish  in   1  renderer finish (last of 128 pixels this cycle)
//  draw_plot    in   1  renderer per-pixel plot
//  bus_req      out  1  VGA write-port request
//  score_enable out  1  renderer run enable
//  tank_num     out  2  glyph slot being rendered
//  erase        out  1  1 = erase pass, 0 = draw pass
//  s1,s2,s3,s4  out  3  latched scores driven to the renderer
//  colour       out  3  VGA colour
//  vga_plot     out  1  VGA write enable
//  busy         out  1  high in any state other than IDLE
//  done         out  1  one-cycle pulse after the draw pass completes
// BEHAVIOUR
//  Reset (resetn=0 at a clk edge):
//   - state=IDLE; s1..s4=0; pending=4'b1111, so the first frame draws every glyph.
//   - All outputs 0, except colour=BG_COLOUR.
//  Staleness:
//   - stale[i] = pending[i] | (t_i != s_i).
//   - refresh sets pending[3:0] on the next edge, including the slot in flight.
//  FSM states: IDLE, REQ, ERASE, DRAW, DONE.
//   - IDLE: if any stale[i] is 1, select the lowest such i into tank_num -> REQ.
//   - REQ: bus_req=1 and wait for grant. On the edge with bus_grant=1:
//     * s_i <= t_i and pending[i] <= 0 (unless refresh is high that cycle);
//     * -> ERASE.
//   - ERASE: score_enable=1, erase=1, colour=BG_COLOUR.
//     * On draw_finish -> DRAW. score_enable stays high.
//     * The renderer counter wraps 127->0, so there is no dead cycle between passes.
//   - DRAW: score_enable=1, erase=0, colour=T<tank_num+1>_COLOUR.
//     * On draw_finish -> DONE.
//   - DONE: done=1; bus_req, score_enable, erase all 0.
//     * Next state is always IDLE (1 cycle).
//  Hold conditions:
//   - bus_req is high in REQ, ERASE and DRAW.
//   - tank_num and s_i are constant from leaving REQ until DONE.
//  vga_plot = draw_plot & score_enable & bus_grant. It is combinational from the registered state.
//  Timing: one glyph takes exactly 256 cycles from first ERASE to last DRAW.
//   - grant -> first pixel: 1 cycle (first ERASE cycle after the grant edge).
//   - Total busy time = REQ wait + 258 cycles.
//  Boundary cases:
//   - Score changes mid-pass: the pass is unaffected (latched s_i). After DONE the slot is still stale and is redrawn.
//   - Several slots stale: served in ascending index order, one pass pair each, with IDLE between them.
//     Every served slot leaves the stale set, so there is no starvation.
//   - bus_grant drops mid-pass: this is an arbiter protocol violation. The pass continues with vga_plot gated to 0 and is not retried.
//   - Scores 4..7: passed through unchanged. The renderer draws blank for them, and the erase pass still runs.
//   - resetn low mid-pass: full reset on that edge, including bus_req=0 and pending=4'b1111.
//   - draw_finish in IDLE, REQ or DONE: ignored.
// STRUCTURE
//  Shared package (tank_pkg):
//   - state encoding (localparams, 3 bits);
//   - the four tank colour constants and BG_COLOUR;
//   - panel slot count = 4.
//  Single module, no sub-modules.
//  Contents: lowest-stale priority encoder, shadow registers, FSM, output decode.
//  Instantiated beside draw_score. draw_score's x/y go straight to the VGA mux.
// TESTING
//  1. Release reset, bus_grant tied 1, all scores 0:
//     4 passes for tank_num 0,1,2,3; each is 128 ERASE + 128 DRAW cycles; 4 done pulses; then IDLE.
//  2. Idle, t3 0->2, grant 1:
//     one pass, tank_num=2, s3=2 from the grant edge; draw colour T3_COLOUR; no other slot touched.
//  3. t1=1 and t4=3 change together, grant held off 20 cycles:
//     bus_req high 20 cycles; tank 0 serviced first, then tank 3.
//  4. t2 1->2 at ERASE cycle 50:
//     s2 stays 1 until DONE; a second pass follows with s2=2.
//  5. refresh pulse during DRAW of slot 1:
//     slot 1 finishes, then all four slots are redrawn in order 0..3.
//  6. resetn low at DRAW cycle 60:
//     next edge bus_req=0, score_enable=0, s*=0; afterwards a full 4-slot redraw.

Source files
------------

// File: rtl/score_panel_ctrl_pkg.sv
// Shared definitions for the score side-panel sequencer: state encoding,
// glyph colours and panel geometry.
package score_panel_ctrl_pkg;

    localparam int NUM_SLOTS = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_ERASE = 3'd2;
    localparam logic [2:0] ST_DRAW  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        REQ   = ST_REQ,
        ERASE = ST_ERASE,
        DRAW  = ST_DRAW,
        DONE  = ST_DONE
    } panel_state_t;

    localparam logic [2:0] PKG_BG_COLOUR = 3'b000;
    localparam logic [2:0] PKG_T1_COLOUR = 3'b100;
    localparam logic [2:0] PKG_T2_COLOUR = 3'b010;
    localparam logic [2:0] PKG_T3_COLOUR = 3'b001;
    localparam logic [2:0] PKG_T4_COLOUR = 3'b110;

endpackage

// File: rtl/score_panel_ctrl_if.sv
// Renderer / VGA write-port bundle between score_panel_ctrl (master) and
// the draw_score renderer plus frame arbiter (slave).
interface score_panel_ctrl_if;
    logic       bus_req;
    logic       bus_grant;
    logic       score_enable;
    logic [1:0] tank_num;
    logic       erase;
    logic       draw_finish;
    logic       draw_plot;
    logic [2:0] s1;
    logic [2:0] s2;
    logic [2:0] s3;
    logic [2:0] s4;
    logic [2:0] colour;
    logic       vga_plot;

    modport master (
        output bus_req, score_enable, tank_num, erase,
        output s1, s2, s3, s4, colour, vga_plot,
        input  bus_grant, draw_finish, draw_plot
    );

    modport slave (
        input  bus_req, score_enable, tank_num, erase,
        input  s1, s2, s3, s4, colour, vga_plot,
        output bus_grant, draw_finish, draw_plot
    );
endinterface

// File: rtl/score_panel_ctrl.sv
// Sequences erase/draw passes of the four score glyphs through the shared
// VGA write port, feeding the renderer latched score copies.
module score_panel_ctrl
    import score_panel_ctrl_pkg::*;
#(
    parameter logic [2:0] BG_COLOUR = PKG_BG_COLOUR,
    parameter logic [2:0] T1_COLOUR = PKG_T1_COLOUR,
    parameter logic [2:0] T2_COLOUR = PKG_T2_COLOUR,
    parameter logic [2:0] T3_COLOUR = PKG_T3_COLOUR,
    parameter logic [2:0] T4_COLOUR = PKG_T4_COLOUR
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [2:0]                t1,
    input  logic [2:0]                t2,
    input  logic [2:0]                t3,
    input  logic [2:0]                t4,
    input  logic                      refresh,
    output logic                      busy,
    output logic                      done,
    score_panel_ctrl_if.master        pif
);

    panel_state_t           state_reg;
    logic [NUM_SLOTS-1:0]   pending_reg;
    logic [2:0]             s_reg [NUM_SLOTS];
    logic [2:0]             t_arr [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]   stale;
    logic [1:0]             tank_num_reg;
    logic [1:0]             first_idx;
    logic                   bus_req_reg;
    logic                   score_enable_reg;
    logic                   erase_reg;
    logic [2:0]             colour_reg;
    logic                   busy_reg;
    logic                   done_reg;

    function automatic logic [2:0] glyph_colour(input logic [1:0] slot);
        case (slot)
            2'd0:    return T1_COLOUR;
            2'd1:    return T2_COLOUR;
            2'd2:    return T3_COLOUR;
            default: return T4_COLOUR;
        endcase
    endfunction

    assign t_arr[0] = t1;
    assign t_arr[1] = t2;
    assign t_arr[2] = t3;
    assign t_arr[3] = t4;

    // A glyph is stale if it was flagged for redraw or the shown score is out of date.
    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_stale
            assign stale[gi] = pending_reg[gi] | (t_arr[gi] != s_reg[gi]);
        end
    endgenerate

    always_comb begin
        first_idx = 2'd0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (stale[i]) first_idx = 2'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg        <= IDLE;
            pending_reg      <= '1;
            tank_num_reg     <= 2'd0;
            bus_req_reg      <= 1'b0;
            score_enable_reg <= 1'b0;
            erase_reg        <= 1'b0;
            colour_reg       <= BG_COLOUR;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) s_reg[i] <= 3'd0;
        end else begin
            done_reg <= 1'b0;
            if (refresh) pending_reg <= '1;

            case (state_reg)
                IDLE: begin
                    if (|stale) begin
                        tank_num_reg <= first_idx;
                        state_reg    <= REQ;
                        bus_req_reg  <= 1'b1;
                        busy_reg     <= 1'b1;
                    end
                end
                REQ: begin
                    // Latch the score on the grant edge so the whole pass pair sees one value.
                    if (pif.bus_grant) begin
                        s_reg[tank_num_reg] <= t_arr[tank_num_reg];
                        if (!refresh) pending_reg[tank_num_reg] <= 1'b0;
                        state_reg        <= ERASE;
                        score_enable_reg <= 1'b1;
                        erase_reg        <= 1'b1;
                        colour_reg       <= BG_COLOUR;
                    end
                end
                ERASE: begin
                    // Renderer counter wraps straight into the draw pass; enable stays high.
                    if (pif.draw_finish) begin
                        state_reg  <= DRAW;
                        erase_reg  <= 1'b0;
                        colour_reg <= glyph_colour(tank_num_reg);
                    end
                end
                DRAW: begin
                    if (pif.draw_finish) begin
                        state_reg        <= DONE;
                        bus_req_reg      <= 1'b0;
                        score_enable_reg <= 1'b0;
                        colour_reg       <= BG_COLOUR;
                        done_reg         <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg        <= IDLE;
                    bus_req_reg      <= 1'b0;
                    score_enable_reg <= 1'b0;
                    erase_reg        <= 1'b0;
                    colour_reg       <= BG_COLOUR;
                    busy_reg         <= 1'b0;
                end
            endcase
        end
    end

    assign pif.bus_req      = bus_req_reg;
    assign pif.score_enable = score_enable_reg;
    assign pif.tank_num     = tank_num_reg;
    assign pif.erase        = erase_reg;
    assign pif.colour       = colour_reg;
    assign pif.s1           = s_reg[0];
    assign pif.s2           = s_reg[1];
    assign pif.s3           = s_reg[2];
    assign pif.s4           = s_reg[3];
    // A grant dropped mid-pass only suppresses writes; the pass itself runs on.
    assign pif.vga_plot     = pif.draw_plot & score_enable_reg & pif.bus_grant;
    assign busy             = busy_reg;
    assign done             = done_reg;

endmodule

// File: tb/tb_score_panel_ctrl.sv
// Self-checking bench for score_panel_ctrl: renderer stand-in, pass-level
// reference model, directed scenarios and a randomized soak.
module tb_score_panel_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic [2:0] t_in [4];
    logic       refresh;
    logic       busy;
    logic       done;
    logic [6:0] rcnt;

    always #5 clk = ~clk;

    score_panel_ctrl_if vif();

    score_panel_ctrl dut (
        .clk     (clk),
        .resetn  (resetn),
        .t1      (t_in[0]),
        .t2      (t_in[1]),
        .t3      (t_in[2]),
        .t4      (t_in[3]),
        .refresh (refresh),
        .busy    (busy),
        .done    (done),
        .pif     (vif.master)
    );

    // Renderer stand-in: 128-pixel counter advancing while enabled, finish on pixel 127.
    always @(posedge clk) begin
        if (!resetn)               rcnt <= 7'd0;
        else if (vif.score_enable) rcnt <= rcnt + 7'd1;
    end
    assign vif.draw_finish = vif.score_enable & (rcnt == 7'd127);

    always @(negedge clk) vif.draw_plot = 1'($urandom_range(0, 1));

    int errors = 0;
    int checks = 0;

    // Reference model: a glyph service is "active" from selection until after its done
    // cycle; m_pix = -1 while waiting for grant, 0..255 pixels, 256 the done cycle.
    logic [2:0] m_s [4];
    logic [3:0] m_pend;
    bit         m_active;
    int         m_slot;
    int         m_pix;
    int         served[$];
    int         done_seen;
    int         erase_cyc;

    logic [2:0] tcol [4];
    initial begin
        tcol[0] = 3'b100; tcol[1] = 3'b010; tcol[2] = 3'b001; tcol[3] = 3'b110;
    end

    function automatic logic [3:0] model_stale();
        logic [3:0] st;
        for (int i = 0; i < 4; i++) st[i] = m_pend[i] | (t_in[i] != m_s[i]);
        return st;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    logic [3:0] np;
    logic [3:0] st;
    int         e_req, e_se, e_er, e_col, e_done;

    always begin
        @(posedge clk);
        if (!resetn) begin
            for (int i = 0; i < 4; i++) m_s[i] = 3'd0;
            m_pend   = 4'hF;
            m_active = 1'b0;
            m_slot   = 0;
            m_pix    = -1;
        end else begin
            np = refresh ? 4'hF : m_pend;
            if (!m_active) begin
                st = model_stale();
                if (st != 4'd0) begin
                    m_active = 1'b1;
                    m_pix    = -1;
                    for (int i = 3; i >= 0; i--) if (st[i]) m_slot = i;
                end
            end else if (m_pix == -1) begin
                if (vif.bus_grant) begin
                    m_s[m_slot] = t_in[m_slot];
                    if (!refresh) np[m_slot] = 1'b0;
                    m_pix = 0;
                end
            end else if (m_pix < 256) begin
                m_pix++;
            end else begin
                m_active = 1'b0;
            end
            m_pend = np;
        end
        #1;
        e_req  = int'(m_active && m_pix < 256);
        e_se   = int'(m_active && m_pix >= 0 && m_pix < 256);
        e_er   = int'(m_active && m_pix >= 0 && m_pix < 128);
        e_col  = (m_active && m_pix >= 128 && m_pix < 256) ? int'(tcol[m_slot]) : 0;
        e_done = int'(m_active && m_pix == 256);
        chk("bus_req",      int'(vif.bus_req),      e_req);
        chk("score_enable", int'(vif.score_enable), e_se);
        chk("erase",        int'(vif.erase),        e_er);
        chk("colour",       int'(vif.colour),       e_col);
        chk("done",         int'(done),             e_done);
        chk("busy",         int'(busy),             int'(m_active));
        chk("tank_num",     int'(vif.tank_num),     m_slot);
        chk("s1",           int'(vif.s1),           int'(m_s[0]));
        chk("s2",           int'(vif.s2),           int'(m_s[1]));
        chk("s3",           int'(vif.s3),           int'(m_s[2]));
        chk("s4",           int'(vif.s4),           int'(m_s[3]));
        chk("vga_plot",     int'(vif.vga_plot),     int'(vif.draw_plot & vif.bus_grant) & e_se);
        if (done) begin
            served.push_back(int'(vif.tank_num));
            done_seen++;
        end
        if (vif.erase) erase_cyc++;
    end

    task automatic clear_log();
        served.delete();
        done_seen = 0;
        erase_cyc = 0;
    endtask

    task automatic wait_quiet(input string nm, input int budget);
        int n = 0;
        while (m_active || model_stale() != 4'd0) begin
            @(negedge clk);
            n++;
            if (n > budget) begin
                checks++;
                errors++;
                $display("FAIL %s timeout: got busy after %0d cycles expected idle", nm, n);
                return;
            end
        end
    endtask

    task automatic wait_pix(input string nm, input int pix);
        int n = 0;
        while (!(m_active && m_pix == pix)) begin
            @(negedge clk);
            n++;
            if (n > 2000) begin
                checks++;
                errors++;
                $display("FAIL %s timeout: got no pixel %0d expected reached", nm, pix);
                return;
            end
        end
    endtask

    // Expected order packed one slot per nibble, first-served slot in the highest used nibble.
    task automatic check_served(input string nm, input int n, input logic [31:0] order);
        chk({nm, "_count"}, served.size(), n);
        for (int k = 0; k < n && k < served.size(); k++)
            chk({nm, "_order"}, served[k], int'(order[4*(n-1-k) +: 4]));
    endtask

    int req_cnt;

    initial begin
        resetn = 1'b0;
        refresh = 1'b0;
        vif.bus_grant = 1'b1;
        for (int i = 0; i < 4; i++) t_in[i] = 3'd0;
        repeat (3) @(negedge clk);
        chk("reset_bus_req", int'(vif.bus_req), 0);
        chk("reset_colour", int'(vif.colour), 0);

        // 1: power-up draws all four glyphs
        resetn = 1'b1;
        clear_log();
        wait_quiet("t1_powerup", 3000);
        check_served("t1", 4, 32'h0123);
        chk("t1_done_pulses", done_seen, 4);
        chk("t1_erase_cycles", erase_cyc, 512);

        // 2: single score change
        clear_log();
        t_in[2] = 3'd2;
        wait_quiet("t2", 1000);
        check_served("t2", 1, 32'h2);
        chk("t2_s3", int'(vif.s3), 2);

        // 3: two changes while the grant is held off
        clear_log();
        vif.bus_grant = 1'b0;
        t_in[0] = 3'd1;
        t_in[3] = 3'd3;
        req_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (vif.bus_req) req_cnt++;
        end
        chk("t3_req_hold", req_cnt, 20);
        vif.bus_grant = 1'b1;
        wait_quiet("t3", 2000);
        check_served("t3", 2, 32'h03);

        // 4: score moves mid-pass, slot served again afterwards
        clear_log();
        t_in[1] = 3'd1;
        wait_pix("t4", 50);
        t_in[1] = 3'd2;
        wait_quiet("t4", 2000);
        check_served("t4", 2, 32'h11);
        chk("t4_s2", int'(vif.s2), 2);

        // 5: refresh during the draw pass of slot 1
        clear_log();
        t_in[1] = 3'd3;
        wait_pix("t5", 150);
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        wait_quiet("t5", 3000);
        check_served("t5", 5, 32'h10123);

        // 6: reset in the middle of a draw pass (score 5 is out of glyph range)
        t_in[0] = 3'd5;
        wait_pix("t6", 188);
        resetn = 1'b0;
        @(negedge clk);
        chk("t6_bus_req", int'(vif.bus_req), 0);
        chk("t6_score_enable", int'(vif.score_enable), 0);
        chk("t6_s1", int'(vif.s1), 0);
        resetn = 1'b1;
        clear_log();
        wait_quiet("t6", 3000);
        check_served("t6", 4, 32'h0123);
        chk("t6_s1_final", int'(vif.s1), 5);

        // randomized soak: score churn, refresh pulses, grant dropouts
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            refresh = 1'($urandom_range(0, 199) == 0);
            vif.bus_grant = 1'($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 59) == 0)
                t_in[$urandom_range(0, 3)] = 3'($urandom_range(0, 7));
        end
        @(negedge clk);
        refresh = 1'b0;
        vif.bus_grant = 1'b1;
        wait_quiet("soak_drain", 5000);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
